bsg_axil_fifo_master: RTL and testbench

Converts a simple valid/ready request/response FIFO interface into AXI4-Lite master transactions. It is the initiator-side counterpart of the AXI-Lite-to-FIFO client. It lets a BlackParrot-side agent (host bridge, debug module, DMA control) drive AXI-Lite peripherals through the same FIFO-style port used elsewhere in the subsystem. Exactly one transaction is outstanding at a time, and every request produces exactly one response beat on the FIFO side.

---
 rtl/bsg_axil_fifo_master_pkg.sv | 16 +
 rtl/bsg_axil_fifo_master_if.sv | 55 +++++
 rtl/bsg_axil_fifo_master_dff_en.sv | 41 ++++
 rtl/bsg_axil_fifo_master.sv | 217 +++++++++++++++++++++
 tb/tb_bsg_axil_fifo_master.sv | 254 +++++++++++++++++++++++++
 5 files changed

// File: rtl/bsg_axil_fifo_master_pkg.sv
// Shared AXI-Lite definitions for the FIFO-to-AXI-Lite master.
// Provides the AXI response encoding (the same encoding as the subsystem AXI
// package) and the fixed protection value that this master drives on AW/AR.
package bsg_axil_fifo_master_pkg;

  typedef enum logic [1:0] {
    e_axi_resp_okay   = 2'b00,
    e_axi_resp_exokay = 2'b01,
    e_axi_resp_slverr = 2'b10,
    e_axi_resp_decerr = 2'b11
  } bsg_axi_resp_e;

  // Unprivileged, secure, data access.
  localparam logic [2:0] axil_prot_default_gp = 3'b000;

endpackage

// File: rtl/bsg_axil_fifo_master_if.sv
// AXI4-Lite bus bundle between an initiator (master modport) and a target
// (slave modport).
//   AW: awaddr, awprot, awvalid (M->S), awready (S->M)
//   W : wdata, wstrb, wvalid (M->S), wready (S->M)
//   B : bresp, bvalid (S->M), bready (M->S)
//   AR: araddr, arprot, arvalid (M->S), arready (S->M)
//   R : rdata, rresp, rvalid (S->M), rready (M->S)
interface bsg_axil_fifo_master_if
  #(parameter int addr_width_p = 32
  , parameter int data_width_p = 32
  );

  localparam int mask_width_lp = data_width_p >> 3;

  logic [addr_width_p-1:0]  awaddr;
  logic [2:0]               awprot;
  logic                     awvalid;
  logic                     awready;

  logic [data_width_p-1:0]  wdata;
  logic [mask_width_lp-1:0] wstrb;
  logic                     wvalid;
  logic                     wready;

  logic [1:0]               bresp;
  logic                     bvalid;
  logic                     bready;

  logic [addr_width_p-1:0]  araddr;
  logic [2:0]               arprot;
  logic                     arvalid;
  logic                     arready;

  logic [data_width_p-1:0]  rdata;
  logic [1:0]               rresp;
  logic                     rvalid;
  logic                     rready;

  modport master
    (output awaddr, awprot, awvalid, input awready
    ,output wdata, wstrb, wvalid, input wready
    ,input bresp, bvalid, output bready
    ,output araddr, arprot, arvalid, input arready
    ,input rdata, rresp, rvalid, output rready
    );

  modport slave
    (input awaddr, awprot, awvalid, output awready
    ,input wdata, wstrb, wvalid, output wready
    ,output bresp, bvalid, input bready
    ,input araddr, arprot, arvalid, output arready
    ,output rdata, rresp, rvalid, input rready
    );

endinterface

// File: rtl/bsg_axil_fifo_master_dff_en.sv
// Enabled register bank used for the request payload and response holding
// registers.
//   clk_i   : clock
//   reset_i : asynchronous active-high reset (only used when reset_p = 1)
//   en_i    : load enable
//   data_i  : next value
//   data_o  : registered value
// With reset_p = 0 the bank has no reset at all (pure datapath storage).
module bsg_axil_fifo_master_dff_en
  #(parameter int width_p = 1
  , parameter bit reset_p = 1'b0
  )
  (input  logic               clk_i
  ,input  logic               reset_i
  ,input  logic               en_i
  ,input  logic [width_p-1:0] data_i
  ,output logic [width_p-1:0] data_o
  );

  logic [width_p-1:0] data_q;

  if (reset_p) begin : g_rst
    always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i)
        data_q <= '0;
      else if (en_i)
        data_q <= data_i;
    end
  end else begin : g_nrst
    logic unused_reset;
    assign unused_reset = reset_i;

    always_ff @(posedge clk_i) begin
      if (en_i)
        data_q <= data_i;
    end
  end

  assign data_o = data_q;

endmodule

// File: rtl/bsg_axil_fifo_master.sv
// FIFO-style request/response port to AXI4-Lite master bridge.
// One transaction is in flight at a time; every accepted request yields
// exactly one response beat.
//   clk_i, reset_i        : clock, asynchronous active-high reset
//   data_i/addr_i/wmask_i : request payload; w_i = 1 write, 0 read
//   v_i / ready_and_o     : request handshake
//   data_o/resp_o/w_o     : response (rdata or 0, bresp/rresp, 1 = write ack)
//   v_o / ready_and_i     : response handshake
//   m_axil                : AXI4-Lite master bus
// All handshake outputs come straight from flops, so nothing on the AXI side
// reaches them combinationally.
module bsg_axil_fifo_master
  import bsg_axil_fifo_master_pkg::*;
  #(parameter int axil_data_width_p = 32
  , parameter int axil_addr_width_p = 32
  , localparam int axil_mask_width_lp = axil_data_width_p >> 3
  )
  (input  logic                          clk_i
  ,input  logic                          reset_i

  ,input  logic [axil_data_width_p-1:0]  data_i
  ,input  logic [axil_addr_width_p-1:0]  addr_i
  ,input  logic                          v_i
  ,input  logic                          w_i
  ,input  logic [axil_mask_width_lp-1:0] wmask_i
  ,output logic                          ready_and_o

  ,output logic [axil_data_width_p-1:0]  data_o
  ,output logic [1:0]                    resp_o
  ,output logic                          w_o
  ,output logic                          v_o
  ,input  logic                          ready_and_i

  ,bsg_axil_fifo_master_if.master        m_axil
  );

  typedef enum logic [2:0] {
    e_idle,
    e_write,
    e_read,
    e_wait_b,
    e_wait_r,
    e_return
  } state_e;

  localparam int lg_mask_lp       = $clog2(axil_mask_width_lp);
  localparam int payload_width_lp = axil_addr_width_p + axil_data_width_p + axil_mask_width_lp;
  localparam int resp_width_lp    = axil_data_width_p + 3;

  state_e state_q, state_d;
  logic   aw_done_q, aw_done_d;
  logic   w_done_q, w_done_d;
  logic   awvalid_q, awvalid_d;
  logic   wvalid_q, wvalid_d;
  logic   arvalid_q, arvalid_d;
  logic   bready_q, bready_d;
  logic   rready_q, rready_d;
  logic   v_q, v_d;
  logic   ready_and_q, ready_and_d;

  logic aw_hs, w_hs, ar_hs, b_hs, r_hs;

  assign aw_hs = awvalid_q & m_axil.awready;
  assign w_hs  = wvalid_q  & m_axil.wready;
  assign ar_hs = arvalid_q & m_axil.arready;
  assign b_hs  = bready_q  & m_axil.bvalid;
  assign r_hs  = rready_q  & m_axil.rvalid;

  // Request payload: loaded on the accept handshake, held for the whole
  // transaction so the AXI payloads stay stable while their valids are up.
  logic                          req_en;
  logic [axil_addr_width_p-1:0]  addr_r;
  logic [axil_data_width_p-1:0]  wdata_r;
  logic [axil_mask_width_lp-1:0] wmask_r;
  logic [payload_width_lp-1:0]   payload_r;

  assign req_en = ready_and_q & v_i;

  bsg_axil_fifo_master_dff_en
    #(.width_p(payload_width_lp), .reset_p(1'b0))
    payload_reg
    (.clk_i   (clk_i)
    ,.reset_i (reset_i)
    ,.en_i    (req_en)
    ,.data_i  ({addr_i, data_i, wmask_i})
    ,.data_o  (payload_r)
    );

  assign {addr_r, wdata_r, wmask_r} = payload_r;

  // Response holding register: loaded on the B or R handshake (mutually
  // exclusive by state) and reset to zero so data_o/resp_o/w_o are defined.
  logic                         resp_en;
  logic [axil_data_width_p-1:0] rsp_data_d;
  bsg_axi_resp_e                rsp_resp_d;
  logic                         rsp_w_d;
  logic [resp_width_lp-1:0]     rsp_r;

  assign resp_en = b_hs | r_hs;

  always_comb begin
    rsp_data_d = m_axil.rdata;
    rsp_resp_d = bsg_axi_resp_e'(m_axil.rresp);
    rsp_w_d    = 1'b0;
    if (b_hs) begin
      rsp_data_d = '0;
      rsp_resp_d = bsg_axi_resp_e'(m_axil.bresp);
      rsp_w_d    = 1'b1;
    end
  end

  bsg_axil_fifo_master_dff_en
    #(.width_p(resp_width_lp), .reset_p(1'b1))
    resp_reg
    (.clk_i   (clk_i)
    ,.reset_i (reset_i)
    ,.en_i    (resp_en)
    ,.data_i  ({rsp_data_d, rsp_resp_d, rsp_w_d})
    ,.data_o  (rsp_r)
    );

  assign {data_o, resp_o, w_o} = rsp_r;

  // Next-state logic. Output flops are decoded from the next state so that
  // each handshake output is a plain register.
  always_comb begin
    state_d   = state_q;
    aw_done_d = aw_done_q;
    w_done_d  = w_done_q;

    unique case (state_q)
      e_idle: begin
        if (v_i)
          state_d = w_i ? e_write : e_read;
      end
      e_write: begin
        aw_done_d = aw_done_q | aw_hs;
        w_done_d  = w_done_q  | w_hs;
        // Both channels done, including handshakes landing this cycle.
        if (aw_done_d & w_done_d) begin
          state_d   = e_wait_b;
          aw_done_d = 1'b0;
          w_done_d  = 1'b0;
        end
      end
      e_read: begin
        if (ar_hs)
          state_d = e_wait_r;
      end
      e_wait_b: begin
        if (b_hs)
          state_d = e_return;
      end
      e_wait_r: begin
        if (r_hs)
          state_d = e_return;
      end
      e_return: begin
        // No bypass: the next request is taken from e_idle.
        if (ready_and_i)
          state_d = e_idle;
      end
      default: state_d = e_idle;
    endcase

    awvalid_d   = (state_d == e_write) & ~aw_done_d;
    wvalid_d    = (state_d == e_write) & ~w_done_d;
    arvalid_d   = (state_d == e_read);
    bready_d    = (state_d == e_wait_b);
    rready_d    = (state_d == e_wait_r);
    v_d         = (state_d == e_return);
    ready_and_d = (state_d == e_idle);
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q     <= e_idle;
      aw_done_q   <= 1'b0;
      w_done_q    <= 1'b0;
      awvalid_q   <= 1'b0;
      wvalid_q    <= 1'b0;
      arvalid_q   <= 1'b0;
      bready_q    <= 1'b0;
      rready_q    <= 1'b0;
      v_q         <= 1'b0;
      ready_and_q <= 1'b1;
    end else begin
      state_q     <= state_d;
      aw_done_q   <= aw_done_d;
      w_done_q    <= w_done_d;
      awvalid_q   <= awvalid_d;
      wvalid_q    <= wvalid_d;
      arvalid_q   <= arvalid_d;
      bready_q    <= bready_d;
      rready_q    <= rready_d;
      v_q         <= v_d;
      ready_and_q <= ready_and_d;
    end
  end

  assign ready_and_o    = ready_and_q;
  assign v_o            = v_q;

  assign m_axil.awaddr  = addr_r;
  assign m_axil.awprot  = axil_prot_default_gp;
  assign m_axil.awvalid = awvalid_q;
  assign m_axil.wdata   = wdata_r;
  assign m_axil.wstrb   = wmask_r;
  assign m_axil.wvalid  = wvalid_q;
  assign m_axil.bready  = bready_q;
  // Reads are issued word-aligned to the bus width.
  assign m_axil.araddr  = {addr_r[axil_addr_width_p-1:lg_mask_lp], {lg_mask_lp{1'b0}}};
  assign m_axil.arprot  = axil_prot_default_gp;
  assign m_axil.arvalid = arvalid_q;
  assign m_axil.rready  = rready_q;

endmodule

// File: tb/tb_bsg_axil_fifo_master.sv
module tb_bsg_axil_fifo_master;

  logic        clk;
  logic        reset_i;
  logic [31:0] data_i;
  logic [31:0] addr_i;
  logic        v_i;
  logic        w_i;
  logic [3:0]  wmask_i;
  logic        ready_and_o;
  logic [31:0] data_o;
  logic [1:0]  resp_o;
  logic        w_o;
  logic        v_o;
  logic        ready_and_i;

  int checks = 0;
  int errors = 0;

  bsg_axil_fifo_master_if #(.addr_width_p(32), .data_width_p(32)) axil ();

  bsg_axil_fifo_master #(.axil_data_width_p(32), .axil_addr_width_p(32)) dut
    (.clk_i       (clk)
    ,.reset_i     (reset_i)
    ,.data_i      (data_i)
    ,.addr_i      (addr_i)
    ,.v_i         (v_i)
    ,.w_i         (w_i)
    ,.wmask_i     (wmask_i)
    ,.ready_and_o (ready_and_o)
    ,.data_o      (data_o)
    ,.resp_o      (resp_o)
    ,.w_o         (w_o)
    ,.v_o         (v_o)
    ,.ready_and_i (ready_and_i)
    ,.m_axil      (axil)
    );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        w;
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  wmask;
    logic [1:0]  slv_resp;
    logic [31:0] slv_rdata;
    logic [31:0] exp_addr;  // expected awaddr (write) or araddr (read)
    logic [31:0] exp_data;  // expected data_o
    logic [1:0]  exp_resp;  // expected resp_o
  } vec_t;

  vec_t vecs[6];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Entered just after a falling edge with the DUT idle; zero-wait slave.
  task automatic run_vec(input vec_t v, input string tag);
    check({tag, "_ready_idle"}, ready_and_o, 1'b1);
    v_i = 1'b1; w_i = v.w; addr_i = v.addr; data_i = v.data; wmask_i = v.wmask;
    @(negedge clk);
    v_i = 1'b0;
    check({tag, "_ready_busy"}, ready_and_o, 1'b0);
    if (v.w) begin
      check({tag, "_awvalid"}, axil.awvalid, 1'b1);
      check({tag, "_wvalid"},  axil.wvalid,  1'b1);
      check({tag, "_arvalid"}, axil.arvalid, 1'b0);
      check({tag, "_awaddr"},  axil.awaddr,  v.exp_addr);
      check({tag, "_wdata"},   axil.wdata,   v.data);
      check({tag, "_wstrb"},   axil.wstrb,   v.wmask);
      check({tag, "_awprot"},  axil.awprot,  3'b000);
      axil.awready = 1'b1; axil.wready = 1'b1;
    end else begin
      check({tag, "_arvalid"}, axil.arvalid, 1'b1);
      check({tag, "_awvalid"}, axil.awvalid, 1'b0);
      check({tag, "_araddr"},  axil.araddr,  v.exp_addr);
      check({tag, "_arprot"},  axil.arprot,  3'b000);
      axil.arready = 1'b1;
    end
    @(negedge clk);
    axil.awready = 1'b0; axil.wready = 1'b0; axil.arready = 1'b0;
    if (v.w) begin
      check({tag, "_bready"},  axil.bready,  1'b1);
      check({tag, "_awdrop"},  axil.awvalid, 1'b0);
      check({tag, "_wdrop"},   axil.wvalid,  1'b0);
      axil.bvalid = 1'b1; axil.bresp = v.slv_resp;
    end else begin
      check({tag, "_rready"},  axil.rready,  1'b1);
      check({tag, "_ardrop"},  axil.arvalid, 1'b0);
      axil.rvalid = 1'b1; axil.rresp = v.slv_resp; axil.rdata = v.slv_rdata;
    end
    @(negedge clk);
    axil.bvalid = 1'b0; axil.rvalid = 1'b0;
    check({tag, "_v_o"},    v_o,         1'b1);
    check({tag, "_bready0"}, axil.bready, 1'b0);
    check({tag, "_rready0"}, axil.rready, 1'b0);
    check({tag, "_data_o"}, data_o,      v.exp_data);
    check({tag, "_resp_o"}, resp_o,      v.exp_resp);
    check({tag, "_w_o"},    w_o,         v.w);
    ready_and_i = 1'b1;
    @(negedge clk);
    ready_and_i = 1'b0;
    check({tag, "_v_o_done"},  v_o,         1'b0);
    check({tag, "_ready_ret"}, ready_and_o, 1'b1);
  endtask

  initial begin
    vecs[0] = '{1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 4'hF, 2'b00, 32'h0,         32'h0000_0010, 32'h0,         2'b00};
    vecs[1] = '{1'b0, 32'h0000_0013, 32'h0,         4'h0, 2'b00, 32'h1234_5678, 32'h0000_0010, 32'h1234_5678, 2'b00};
    vecs[2] = '{1'b1, 32'h0000_002A, 32'hA5A5_0001, 4'h3, 2'b10, 32'h0,         32'h0000_002A, 32'h0,         2'b10};
    vecs[3] = '{1'b0, 32'h0000_0104, 32'h0,         4'h0, 2'b00, 32'hCAFE_F00D, 32'h0000_0104, 32'hCAFE_F00D, 2'b00};
    vecs[4] = '{1'b0, 32'h0000_0007, 32'h0,         4'h0, 2'b11, 32'h0F0F_0F0F, 32'h0000_0004, 32'h0F0F_0F0F, 2'b11};
    vecs[5] = '{1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 4'h8, 2'b01, 32'h0,         32'hFFFF_FFFF, 32'h0,         2'b01};

    reset_i = 1'b0; v_i = 1'b0; w_i = 1'b0; addr_i = '0; data_i = '0; wmask_i = '0;
    ready_and_i = 1'b0;
    axil.awready = 1'b0; axil.wready = 1'b0; axil.arready = 1'b0;
    axil.bvalid = 1'b0; axil.bresp = 2'b00;
    axil.rvalid = 1'b0; axil.rresp = 2'b00; axil.rdata = '0;

    // Asynchronous reset before any clock edge.
    #1 reset_i = 1'b1;
    #1;
    check("rst_ready_and", ready_and_o, 1'b1);
    check("rst_v_o",       v_o,         1'b0);
    check("rst_awvalid",   axil.awvalid, 1'b0);
    check("rst_wvalid",    axil.wvalid,  1'b0);
    check("rst_arvalid",   axil.arvalid, 1'b0);
    check("rst_bready",    axil.bready,  1'b0);
    check("rst_rready",    axil.rready,  1'b0);
    check("rst_data_o",    data_o,       32'h0);
    check("rst_resp_o",    resp_o,       2'b00);
    check("rst_w_o",       w_o,          1'b0);
    @(negedge clk);
    @(negedge clk);
    reset_i = 1'b0;
    @(negedge clk);

    // Table: zero-wait slave, writes and reads incl. error responses.
    for (int i = 0; i < 6; i++)
      run_vec(vecs[i], $sformatf("vec%0d", i));

    // Skewed write: AW handshakes at once, W five cycles later.
    v_i = 1'b1; w_i = 1'b1; addr_i = 32'h40; data_i = 32'h0BAD_F00D; wmask_i = 4'hC;
    @(negedge clk);
    v_i = 1'b0;
    check("skew_awvalid", axil.awvalid, 1'b1);
    check("skew_wvalid",  axil.wvalid,  1'b1);
    axil.awready = 1'b1;
    @(negedge clk);
    axil.awready = 1'b0;
    check("skew_aw_drop", axil.awvalid, 1'b0);
    check("skew_w_hold",  axil.wvalid,  1'b1);
    check("skew_bready0", axil.bready,  1'b0);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check($sformatf("skew_w_hold%0d", k),  axil.wvalid,  1'b1);
      check($sformatf("skew_aw_low%0d", k),  axil.awvalid, 1'b0);
      check($sformatf("skew_bready%0d", k),  axil.bready,  1'b0);
    end
    check("skew_wdata_stable", axil.wdata, 32'h0BAD_F00D);
    check("skew_wstrb_stable", axil.wstrb, 4'hC);
    axil.wready = 1'b1;
    @(negedge clk);
    axil.wready = 1'b0;
    check("skew_w_drop", axil.wvalid, 1'b0);
    check("skew_bready", axil.bready, 1'b1);
    axil.bvalid = 1'b1; axil.bresp = 2'b00;
    @(negedge clk);
    axil.bvalid = 1'b0;
    check("skew_v_o", v_o, 1'b1);
    check("skew_w_o", w_o, 1'b1);
    ready_and_i = 1'b1;
    @(negedge clk);
    ready_and_i = 1'b0;

    // Backpressure in e_return with a new request waiting.
    v_i = 1'b1; w_i = 1'b0; addr_i = 32'h21;
    @(negedge clk);
    v_i = 1'b0;
    check("bp_araddr", axil.araddr, 32'h20);
    axil.arready = 1'b1;
    @(negedge clk);
    axil.arready = 1'b0;
    axil.rvalid = 1'b1; axil.rdata = 32'h55AA_33CC; axil.rresp = 2'b00;
    @(negedge clk);
    axil.rvalid = 1'b0; axil.rdata = 32'hFFFF_FFFF;
    v_i = 1'b1; w_i = 1'b1; addr_i = 32'h80; data_i = 32'h1122_3344; wmask_i = 4'hF;
    for (int k = 0; k < 10; k++) begin
      check($sformatf("bp_v_o%0d", k),   v_o,         1'b1);
      check($sformatf("bp_data%0d", k),  data_o,      32'h55AA_33CC);
      check($sformatf("bp_ready%0d", k), ready_and_o, 1'b0);
      @(negedge clk);
    end
    ready_and_i = 1'b1;
    @(negedge clk);
    ready_and_i = 1'b0;
    check("bp_release_ready", ready_and_o, 1'b1);
    check("bp_release_v_o",   v_o,         1'b0);
    @(negedge clk);
    v_i = 1'b0;
    check("bp_new_awvalid", axil.awvalid, 1'b1);
    check("bp_new_awaddr",  axil.awaddr,  32'h80);
    axil.awready = 1'b1; axil.wready = 1'b1;
    @(negedge clk);
    axil.awready = 1'b0; axil.wready = 1'b0;
    axil.bvalid = 1'b1; axil.bresp = 2'b00;
    @(negedge clk);
    axil.bvalid = 1'b0;
    check("bp_new_v_o", v_o, 1'b1);
    check("bp_new_w_o", w_o, 1'b1);
    ready_and_i = 1'b1;
    @(negedge clk);
    ready_and_i = 1'b0;

    // Asynchronous reset mid-cycle while waiting for R.
    v_i = 1'b1; w_i = 1'b0; addr_i = 32'h30;
    @(negedge clk);
    v_i = 1'b0;
    axil.arready = 1'b1;
    @(negedge clk);
    axil.arready = 1'b0;
    check("arst_pre_rready", axil.rready, 1'b1);
    #2 reset_i = 1'b1;
    #1;
    check("arst_rready",  axil.rready,  1'b0);
    check("arst_arvalid", axil.arvalid, 1'b0);
    check("arst_awvalid", axil.awvalid, 1'b0);
    check("arst_wvalid",  axil.wvalid,  1'b0);
    check("arst_bready",  axil.bready,  1'b0);
    check("arst_v_o",     v_o,          1'b0);
    check("arst_ready",   ready_and_o,  1'b1);
    check("arst_w_o",     w_o,          1'b0);
    check("arst_data_o",  data_o,       32'h0);
    @(negedge clk);
    reset_i = 1'b0;
    @(negedge clk);
    check("arst_post_ready", ready_and_o, 1'b1);
    check("arst_post_v_o",   v_o,         1'b0);
    check("arst_post_rready", axil.rready, 1'b0);
    run_vec(vecs[1], "post_rst");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
